// File: rtl/led_rgb_pkg.sv
// Shared colour codes and FSM state encoding for the RGB status LED sequencer.
package led_rgb_pkg;

    localparam logic [2:0] OFF    = 3'b000;
    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b011;
    localparam logic [2:0] BLUE   = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        ALARM = 2'd2
    } state_e;

endpackage

// File: rtl/led_rgb_sequencer_blink_tick_gen.sv
// Blink timebase: half-period counter plus ON/OFF phase flop, restartable to a fresh ON half.
module blink_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic restart,
    output logic tick,
    output logic phase
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          phase_q, phase_d;

    assign tick  = (count_q == LAST);
    assign phase = phase_q;

    always_comb begin
        count_d = count_q + CW'(1);
        phase_d = phase_q;
        if (restart) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (tick) begin
            count_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= 1'b1;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/led_rgb_sequencer.sv
// RGB status LED arbiter: alarm blink over one-shot flash events over background status colour.
module led_rgb_sequencer
    import led_rgb_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int FLASH_TICKS = 6
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [2:0] status_color,
    input  logic       status_blink,
    input  logic       evt_valid,
    input  logic [2:0] evt_color,
    output logic       evt_ready,
    input  logic       alarm,
    output logic       busy,
    output logic [2:0] rgb_out
);

    localparam int FW = $clog2(FLASH_TICKS + 1);

    state_e        state_q, state_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic [2:0]    cap_q, cap_d;
    logic [2:0]    rgb_q, rgb_d;
    logic          busy_q, busy_d;
    logic [2:0]    color_prev_q;
    logic          blink_prev_q;
    logic          tick, phase, restart, phase_nxt, accept;

    assign evt_ready = (state_q == IDLE) & ~alarm & ~rst;
    assign accept    = evt_valid & evt_ready;
    assign busy      = busy_q;
    assign rgb_out   = rgb_q;

    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        cap_d       = cap_q;
        case (state_q)
            IDLE: begin
                if (alarm) begin
                    state_d = ALARM;
                end else if (accept) begin
                    state_d     = FLASH;
                    flash_cnt_d = FW'(FLASH_TICKS);
                    cap_d       = evt_color;
                end
            end
            FLASH: begin
                if (alarm) begin
                    state_d     = ALARM;
                    flash_cnt_d = '0;
                end else if (tick) begin
                    flash_cnt_d = flash_cnt_q - FW'(1);
                    if (flash_cnt_q == FW'(1)) state_d = IDLE;
                end
            end
            ALARM: begin
                if (!alarm) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any new colour source, background colour or blink enable starts on a full ON half-period.
    assign restart = (state_d != state_q)
                   | ((state_q == IDLE) & (status_color != color_prev_q))
                   | (status_blink & ~blink_prev_q);

    // Outputs are registered, so they are computed from the phase the timebase will hold next.
    assign phase_nxt = restart ? 1'b1 : (phase ^ tick);

    always_comb begin
        rgb_d  = OFF;
        busy_d = (state_d != IDLE);
        case (state_d)
            IDLE:    rgb_d = (status_blink & ~phase_nxt) ? OFF : status_color;
            FLASH:   rgb_d = phase_nxt ? cap_d : OFF;
            ALARM:   rgb_d = phase_nxt ? RED : OFF;
            default: rgb_d = OFF;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            flash_cnt_q  <= '0;
            cap_q        <= OFF;
            rgb_q        <= OFF;
            busy_q       <= 1'b0;
            color_prev_q <= OFF;
            blink_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flash_cnt_q  <= flash_cnt_d;
            cap_q        <= cap_d;
            rgb_q        <= rgb_d;
            busy_q       <= busy_d;
            color_prev_q <= status_color;
            blink_prev_q <= status_blink;
        end
    end

    blink_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_blink (
        .clk_in  (clk_in),
        .rst     (rst),
        .restart (restart),
        .tick    (tick),
        .phase   (phase)
    );

endmodule

// File: doc/led_rgb_sequencer.md
Name: led_rgb_sequencer

Overview:
Owns the single RGB status LED of the digital lock and decides what it shows each cycle.
It arbitrates between three sources, highest priority first:
- alarm: continuous red blink
- one-shot feedback flash events: accept, reject, key-press
- the lock FSM's steady or blinking background status colour

It generates blink timing internally and drives the 3-bit colour code straight to the LED pins.

Parameters:
TICK_DIV, 50_000_000, clk_in cycles per blink half-period (0.5 s at 100 MHz); legal range >= 2
FLASH_TICKS, 6, half-periods per flash event (6 = three on/off blinks); legal range >= 1

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous active-high reset
status_color  input  3  background colour code from the lock FSM
status_blink  input  1  1 = background blinks, 0 = background solid
evt_valid  input  1  flash request valid
evt_color  input  3  flash colour, sampled on handshake
evt_ready  output  1  flash request can be accepted this cycle
alarm  input  1  level; while high, LED blinks RED and preempts everything
busy  output  1  high while in FLASH or ALARM
rgb_out  output  3  LED drive, bit0 = R, bit1 = G, bit2 = B

Behaviour:
- Colour codes: OFF 000, RED 001, GREEN 010, YELLOW 011, BLUE 100, WHITE 111.
- Reset (asynchronous, active-high):
  - state = IDLE, rgb_out = 000, busy = 0, tick counter = 0, phase = ON, flash counter = 0.
  - evt_ready = 0 while rst is high.
- All outputs except evt_ready are registered. They update on the same edge as the state transition that causes them, so each value is visible the cycle after that edge.
- evt_ready is combinational: (state == IDLE) & ~alarm & ~rst.
- Handshake: an event is accepted on a rising edge where evt_valid & evt_ready. evt_color is captured on that edge. Requests made while not ready are not queued; the requester holds evt_valid.
- Blink timebase:
  - Counter runs 0..TICK_DIV-1.
  - tick = 1 when count == TICK_DIV-1; phase toggles on tick.
  - Restart (count <= 0, phase <= ON) on any state change, on a status_color change while in IDLE, and on a status_blink rising edge.
  - Result: every new colour starts with a full ON half-period.
- States:
  - IDLE:
    - rgb_out = status_color if status_blink = 0, else (phase ? status_color : OFF).
    - alarm -> ALARM.
    - Accepted event -> FLASH, flash counter <= FLASH_TICKS.
  - FLASH:
    - rgb_out = phase ? captured colour : OFF.
    - Flash counter decrements on each tick.
    - On the tick where the counter == 1 -> IDLE.
    - Total duration is exactly FLASH_TICKS*TICK_DIV cycles.
    - alarm -> ALARM; the flash is discarded, not resumed.
  - ALARM:
    - rgb_out = phase ? RED : OFF.
    - Stays while alarm = 1; alarm = 0 -> IDLE, with blink phase restarted.
- Simultaneous events:
  - alarm rising in the same cycle as evt_valid: evt_ready is already 0, the event is not accepted, and ALARM wins.
  - status_color change during FLASH or ALARM has no visible effect; the new value is shown on return to IDLE.
- evt_color = OFF is legal and produces a dark flash of full duration.
- busy = (next state != IDLE), registered.
- Reset mid-FLASH or mid-ALARM: immediate return to IDLE and rgb_out = 000. The captured flash is lost.
- Counter widths are $clog2 of TICK_DIV and FLASH_TICKS+1. No wrap-around beyond the terminal counts.

Decomposition:
- Shared package led_rgb_pkg:
  - colour localparams OFF, RED, GREEN, YELLOW, BLUE, WHITE
  - 2-bit state encoding: IDLE = 0, FLASH = 1, ALARM = 2
- One sub-module, blink_tick_gen:
  - parameter TICK_DIV
  - inputs: clk_in, rst, restart
  - outputs: tick, phase
  - contains the half-period counter and phase flop; restart behaves as specified above.
- The FSM, flash counter, capture register and output mux live in led_rgb_sequencer.

Test Plan:
1. TICK_DIV = 4, FLASH_TICKS = 4. Release rst, status_color = 010, status_blink = 0 -> rgb_out = 000 during reset, then 010 steady; evt_ready = 1, busy = 0.
2. status_blink 0 -> 1 with status_color = 100 -> rgb_out = 100 for 4 cycles, 000 for 4, 100 for 4, repeating; first ON half is full length.
3. evt_valid = 1, evt_color = 010 for one cycle while background is YELLOW solid, then:
   - Required: rgb_out = 010 x4, 000 x4, 010 x4, 000 x4, then 011.
   - busy is high for exactly 16 cycles; evt_ready is 0 throughout.
4. alarm = 1 at cycle 6 of a flash -> next cycle rgb_out = 001, then alternates 001/000 every 4 cycles. alarm = 0 -> returns to background with no flash residue.
5. alarm and evt_valid rise in the same cycle -> event not accepted, ALARM entered, evt_ready = 0. After alarm drops, a still-held evt_valid is accepted and a full flash follows.
6. Assert rst mid-flash, asynchronously between edges -> rgb_out = 000 and busy = 0 immediately. After release: IDLE, background colour, fresh ON phase.
